// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch port and the data port.
// Sequences power-up settle, one access at a time, fixed read latency and fetch squash on PC change.
module mem_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 2,
  parameter int INIT_CYC    = 8,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] INIT_LAST = 8'(INIT_CYC - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);
  localparam logic [3:0] DB_MAX    = 4'(MAX_D_BURST);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] dburst;
  logic       own_d;
  logic       lat_we;
  logic       squash;
  logic       if_ok;
  logic       grant_d;
  logic       grant_i;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == DB_MAX) ? v : v + 4'd1;
  endfunction

  // A flushed fetch is not a candidate; data yields only once its burst budget is used up.
  assign if_ok   = if_req & ~if_flush;
  assign grant_d = d_req & ~(if_ok & (dburst == DB_MAX));
  assign grant_i = if_ok & ~grant_d;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_INIT;
      cnt       <= '0;
      dburst    <= '0;
      own_d     <= 1'b0;
      lat_we    <= 1'b0;
      squash    <= 1'b0;
      mem_csb   <= 1'b1;
      mem_web   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (!if_req) dburst <= '0;
      case (state)
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_IDLE: begin
          if (grant_d || grant_i) begin
            own_d    <= grant_d;
            lat_we   <= grant_d & d_we;
            mem_addr <= grant_d ? d_addr : if_addr;
            if (grant_d) mem_wdata <= d_wdata;
            mem_csb  <= 1'b0;
            mem_web  <= ~(grant_d & d_we);
            state    <= S_ACCESS;
            if (grant_i)     dburst <= '0;
            else if (if_req) dburst <= sat_inc(dburst);
          end
        end
        S_ACCESS: begin
          mem_csb <= 1'b1;
          mem_web <= 1'b1;
          if (!own_d && if_flush) squash <= 1'b1;
          cnt <= '0;
          if (lat_we) begin
            d_valid <= 1'b1;
            state   <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!own_d && if_flush) squash <= 1'b1;
          if (cnt == RD_LAST) begin
            cnt   <= '0;
            state <= S_RESP;
            if (own_d) begin
              d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end else if (!(squash || if_flush)) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          squash <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural SRAM, response queues per port and a grant-order queue.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 10, DATA_W = 32, RD_LAT = 2, INIT_CYC = 8, MAX_D_BURST = 4;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk, rstn;
  logic if_req, if_flush, if_valid, if_stall;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic d_req, d_we, d_valid, d_stall;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic mem_csb, mem_web;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  exp_t if_q[$];
  exp_t d_q[$];
  logic [ADDR_W-1:0] g_q[$];
  logic [DATA_W-1:0] sram [1024];
  logic [DATA_W-1:0] model[1024];
  logic [DATA_W-1:0] last_if = '0;
  logic g_en = 1'b0;
  logic load = 1'b1;
  int grants = 0;
  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
                     .INIT_CYC(INIT_CYC), .MAX_D_BURST(MAX_D_BURST)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    if (i == 'h010) return 32'hDEADBEEF;
    if (i == 'h020) return 32'h12345678;
    return 32'hC0DE0000 ^ 32'(i * 7);
  endfunction

  // Behavioural SRAM: read data registered on the access edge and held.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
      mem_rdata <= '0;
    end else if (!mem_csb) begin
      if (!mem_web) sram[mem_addr] <= mem_wdata;
      else          mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (if_valid) begin
        if (if_q.size() == 0) check_eq("if_unexpected_valid", 32'(if_valid), 32'd0);
        else begin
          e = if_q.pop_front();
          check_eq("if_rdata", if_rdata, e.data);
          last_if = e.data;
        end
      end
      if (d_valid) begin
        if (d_q.size() == 0) check_eq("d_unexpected_valid", 32'(d_valid), 32'd0);
        else begin
          e = d_q.pop_front();
          if (e.we) check_eq("d_write_sram", sram[e.addr], e.data);
          else      check_eq("d_rdata", d_rdata, e.data);
        end
      end
      if (g_en && !mem_csb) begin
        grants++;
        if (g_q.size() == 0) check_eq("grant_extra", 32'(mem_addr), 32'hFFFFFFFF);
        else check_eq("grant_order", 32'(mem_addr), 32'(g_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_check(input bit port_d, input string tag);
    for (int i = 0; i < INIT_CYC; i++) begin
      @(negedge clk);
      check_eq({tag, "_init_csb"}, 32'(mem_csb), 32'd1);
      check_eq({tag, "_init_stall"}, 32'(port_d ? d_stall : if_stall), 32'd1);
      step();
    end
    @(negedge clk);
    check_eq({tag, "_idle_csb"}, 32'(mem_csb), 32'd1);
    step();
    @(negedge clk);
    check_eq({tag, "_first_access"}, 32'(mem_csb), 32'd0);
  endtask

  task automatic finish_txn(input bit port_d, input int exp_lat, input string tag);
    int n = 1;
    while (!(port_d ? d_valid : if_valid) && n < 40) begin
      step();
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
    step();
    if (port_d) d_req = 1'b0;
    else        if_req = 1'b0;
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(port_d ? d_valid : if_valid), 32'd0);
  endtask

  task automatic txn(input bit port_d, input bit we, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] wd, input string tag);
    exp_t e;
    step();
    e.we = we;
    e.addr = a;
    e.data = we ? wd : model[a];
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      d_q.push_back(e);
      if (we) model[a] = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
      if_q.push_back(e);
    end
    @(negedge clk);
    step();
    @(negedge clk);
    check_eq({tag, "_csb"}, 32'(mem_csb), 32'd0);
    check_eq({tag, "_web"}, 32'(mem_web), we ? 32'd0 : 32'd1);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'(a));
    if (we) check_eq({tag, "_wdata"}, mem_wdata, wd);
    finish_txn(port_d, we ? 2 : RD_LAT + 2, tag);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((if_q.size() != 0 || d_q.size() != 0 || g_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_drain"}, 32'(if_q.size() + d_q.size() + g_q.size()), 32'd0);
  endtask

  task automatic wait_grants(input int target, input string tag);
    int t = 0;
    while (grants < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_grants"}, 32'(grants), 32'(target));
  endtask

  initial begin
    exp_t e;
    int nv;
    for (int i = 0; i < 1024; i++) model[i] = init_val(i);
    rstn = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req = 1'b1; if_addr = 10'h010;
    step();
    load = 1'b0;
    @(negedge clk);
    check_eq("rst_csb", 32'(mem_csb), 32'd1);
    check_eq("rst_web", 32'(mem_web), 32'd1);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", mem_wdata, 32'd0);
    check_eq("rst_valid", 32'({if_valid, d_valid}), 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);

    // Reset release with a fetch already pending: settle, then first fetch.
    e.we = 1'b0; e.addr = 10'h010; e.data = model[10'h010];
    if_q.push_back(e);
    step();
    rstn = 1'b1;
    settle_check(1'b0, "t1");
    check_eq("t1_addr", 32'(mem_addr), 32'h010);
    finish_txn(1'b0, RD_LAT + 2, "t2");
    txn(1'b0, 1'b0, 10'h010, '0, "t2b");

    txn(1'b1, 1'b1, 10'h3FF, 32'hA5A5A5A5, "t3w");
    txn(1'b1, 1'b0, 10'h3FF, '0, "t3r");
    txn(1'b1, 1'b1, 10'h000, 32'h0BADF00D, "t3w0");
    txn(1'b1, 1'b0, 10'h000, '0, "t3r0");

    // Both ports hammering: data bursts of MAX_D_BURST, then one fetch.
    step();
    if_addr = 10'h100; d_addr = 10'h200; d_we = 1'b0;
    for (int k = 0; k < 10; k++) g_q.push_back((k % 5 == 4) ? 10'h100 : 10'h200);
    e.we = 1'b0;
    e.addr = 10'h100; e.data = model[10'h100];
    repeat (2) if_q.push_back(e);
    e.addr = 10'h200; e.data = model[10'h200];
    repeat (8) d_q.push_back(e);
    grants = 0; g_en = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    wait_grants(10, "t4_mixed");
    step();
    if_req = 1'b0; d_req = 1'b0;
    drain("t4_mixed");

    for (int k = 0; k < 3; k++) begin
      g_q.push_back(10'h200);
      d_q.push_back(e);
    end
    grants = 0;
    step();
    d_req = 1'b1;
    wait_grants(3, "t4_donly");
    step();
    d_req = 1'b0;
    drain("t4_donly");
    g_en = 1'b0;

    // A fetch presented together with a flush is never granted.
    step();
    if_req = 1'b1; if_flush = 1'b1; if_addr = 10'h020;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("flush_idle_csb", 32'(mem_csb), 32'd1);
      step();
    end
    if_req = 1'b0; if_flush = 1'b0;

    // Flush during WAIT: access happens, response squashed.
    step();
    if_req = 1'b1; if_addr = 10'h020;
    @(negedge clk);
    step();
    @(negedge clk);
    check_eq("t5_csb", 32'(mem_csb), 32'd0);
    check_eq("t5_addr", 32'(mem_addr), 32'h020);
    step();
    if_flush = 1'b1;
    @(negedge clk);
    step();
    if_flush = 1'b0; if_req = 1'b0;
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_valid) nv++;
    end
    check_eq("t5_no_valid", 32'(nv), 32'd0);
    check_eq("t5_rdata_hold", if_rdata, last_if);
    txn(1'b0, 1'b0, 10'h020, '0, "t5_next");

    // Reset in the middle of a data read.
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h030;
    @(negedge clk);
    step();
    @(negedge clk);
    check_eq("t6_access", 32'(mem_csb), 32'd0);
    step();
    rstn = 1'b0;
    #1;
    check_eq("t6_rst_csb", 32'(mem_csb), 32'd1);
    check_eq("t6_rst_valid", 32'(d_valid), 32'd0);
    check_eq("t6_rst_addr", 32'(mem_addr), 32'd0);
    check_eq("t6_rst_stall", 32'(d_stall), 32'd1);
    step();
    e.we = 1'b0; e.addr = 10'h030; e.data = model[10'h030];
    d_q.push_back(e);
    rstn = 1'b1;
    settle_check(1'b1, "t6");
    check_eq("t6_addr", 32'(mem_addr), 32'h030);
    finish_txn(1'b1, RD_LAT + 2, "t6r");
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end

endmodule
